// File: rtl/mem_result_checker_if.sv
// Memory read port between the result checker (master) and the memory under test (slave).
// Read data returns exactly one cycle after the read strobe.
interface mem_result_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_rd, output mem_addr, input  mem_rdata);
  modport slave  (input  mem_rd, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/mem_result_checker.sv
// End-of-program checker: waits for CPU halt, checks the halt PC, then reads back and compares a
// table of (address, word) pairs. Optional macro MRC_CONTINUE_ON_ERR_EN keeps comparing after a mismatch.
module mem_result_checker #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int PC_W           = 9,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         halt,
  input  logic [PC_W-1:0]              pc,
  input  logic [PC_W-1:0]              exp_pc,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  mem_result_checker_if.master         mem,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [3:0]                   fail_idx,
  output logic [4:0]                   err_count,
  output logic [31:0]                  cycles
);

  typedef enum logic [2:0] {RUN, CHK_PC, RD, CMP, DONE} state_t;

  localparam logic [3:0]  LAST_IDX = 4'(NUM_CHECKS - 1);
  localparam logic [31:0] TIMEOUT  = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_PC      = 2'd2;
  localparam logic [1:0] FC_DATA    = 2'd3;

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt;
  logic [31:0]       cyc_q, cyc_nxt, cyc_inc;
  logic [1:0]        fc_q, fc_nxt;
  logic [3:0]        fidx_q, fidx_nxt;
  logic [4:0]        errs_q, errs_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] cur_data;
  logic              mismatch;

  assign cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
  assign cur_data = chk_data[int'(idx) * DATA_W +: DATA_W];
  assign nxt_addr = chk_addr[int'(idx_nxt) * ADDR_W +: ADDR_W];
  assign mismatch = (mem.mem_rdata != cur_data);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cyc_nxt   = cyc_q;
    fc_nxt    = fc_q;
    fidx_nxt  = fidx_q;
    errs_nxt  = errs_q;
    case (state)
      RUN: begin
        cyc_nxt = cyc_inc;
        // halt takes priority over a timeout landing on the same cycle
        if (halt) begin
          state_nxt = CHK_PC;
        end else if (cyc_inc >= TIMEOUT) begin
          state_nxt = DONE;
          fc_nxt    = FC_TIMEOUT;
        end
      end
      CHK_PC: begin
        if (pc == exp_pc) begin
          state_nxt = RD;
          idx_nxt   = 4'd0;
        end else begin
          state_nxt = DONE;
          fc_nxt    = FC_PC;
        end
      end
      RD: state_nxt = CMP;
      CMP: begin
        if (mismatch) begin
          errs_nxt = errs_q + 5'd1;
          if (fc_q == FC_NONE) begin
            fc_nxt   = FC_DATA;
            fidx_nxt = idx;
          end
        end
`ifdef MRC_CONTINUE_ON_ERR_EN
        if (idx == LAST_IDX) begin
`else
        if (mismatch || idx == LAST_IDX) begin
`endif
          state_nxt = DONE;
        end else begin
          state_nxt = RD;
          idx_nxt   = idx + 4'd1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx    <= 4'd0;
      cyc_q  <= 32'd0;
      fc_q   <= FC_NONE;
      fidx_q <= 4'd0;
      errs_q <= 5'd0;
      addr_q <= '0;
    end else begin
      idx    <= idx_nxt;
      cyc_q  <= cyc_nxt;
      fc_q   <= fc_nxt;
      fidx_q <= fidx_nxt;
      errs_q <= errs_nxt;
      // address is latched on entry to RD and held afterwards
      if (state_nxt == RD) addr_q <= nxt_addr;
    end
  end

  assign mem.mem_rd   = (state == RD);
  assign mem.mem_addr = addr_q;

  assign busy      = (state != DONE);
  assign done      = (state == DONE);
  assign pass      = done && (fc_q == FC_NONE);
  assign fail_code = fc_q;
  assign fail_idx  = fidx_q;
  assign err_count = errs_q;
  assign cycles    = cyc_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Bench for mem_result_checker: one single-entry instance and one 4-entry instance with a short timeout;
// expected read addresses are queued at setup and matched against observed read strobes.
module tb_mem_result_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        halt = 1'b0;
  logic [8:0]  pc = '0, exp_pc = '0;
  logic [7:0]  chk_addr1 = '0;
  logic [15:0] chk_data1 = '0;
  logic [31:0] chk_addr4 = '0;
  logic [63:0] chk_data4 = '0;

  logic        busy1, done1, pass1, busy4, done4, pass4;
  logic [1:0]  fc1, fc4;
  logic [3:0]  fi1, fi4;
  logic [4:0]  ec1, ec4;
  logic [31:0] cyc1, cyc4;

  mem_result_checker_if #(.ADDR_W(8), .DATA_W(16)) m1();
  mem_result_checker_if #(.ADDR_W(8), .DATA_W(16)) m4();

  mem_result_checker #(.DATA_W(16), .ADDR_W(8), .PC_W(9), .NUM_CHECKS(1), .TIMEOUT_CYCLES(65535)) u_one (
    .clk(clk), .reset_n(reset_n), .halt(halt), .pc(pc), .exp_pc(exp_pc),
    .chk_addr(chk_addr1), .chk_data(chk_data1), .mem(m1.master),
    .busy(busy1), .done(done1), .pass(pass1), .fail_code(fc1), .fail_idx(fi1),
    .err_count(ec1), .cycles(cyc1));

  mem_result_checker #(.DATA_W(16), .ADDR_W(8), .PC_W(9), .NUM_CHECKS(4), .TIMEOUT_CYCLES(50)) u_four (
    .clk(clk), .reset_n(reset_n), .halt(halt), .pc(pc), .exp_pc(exp_pc),
    .chk_addr(chk_addr4), .chk_data(chk_data4), .mem(m4.master),
    .busy(busy4), .done(done4), .pass(pass4), .fail_code(fc4), .fail_idx(fi4),
    .err_count(ec4), .cycles(cyc4));

  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (m1.mem_rd) m1.mem_rdata <= mem[m1.mem_addr];
    if (m4.mem_rd) m4.mem_rdata <= mem[m4.mem_addr];
  end

  logic [7:0] obs1[$], obs4[$], exp1[$], exp4[$];
  always @(negedge clk) begin
    if (m1.mem_rd === 1'b1) obs1.push_back(m1.mem_addr);
    if (m4.mem_rd === 1'b1) obs4.push_back(m4.mem_addr);
  end

  int errors = 0;
  int checks = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    halt    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    obs1.delete();
    obs4.delete();
  endtask

  // called at the negedge right after reset release; halt is seen on RUN cycle n (n >= 2)
  task automatic halt_at(input int n);
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic wait_done(input bit four, input int max, output int n);
    n = 0;
    while (n < max && !(four ? done4 : done1)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_table4(input logic [15:0] d0, d1, d2, d3);
    chk_addr4 = {8'h23, 8'h22, 8'h21, 8'h20};
    chk_data4 = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy4, done4, pass4, m4.mem_rd} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/pass/rd=%b want 1000", {busy4, done4, pass4, m4.mem_rd});
    end
    checks++;
    if (cyc4 !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cyc4); end
    checks++;
    if ({fc4, fi4, ec4} !== 11'd0) begin
      errors++; $display("FAIL reset_status: fc=%0d fi=%0d ec=%0d want 0", fc4, fi4, ec4);
    end
  endtask

  task automatic test_correct_run();
    int n;
    exp_pc = 9'hF; pc = 9'hF;
    chk_addr1 = 8'h14; chk_data1 = 16'd850;
    do_reset();
    exp1.push_back(8'h14);
    halt_at(200);
    wait_done(1'b0, 20, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL run_latency: got %0d want 3", n); end
    checks++;
    if ({done1, pass1, busy1, fc1} !== 5'b11000) begin
      errors++; $display("FAIL run_status: done=%b pass=%b busy=%b fc=%0d want 1 1 0 0", done1, pass1, busy1, fc1);
    end
    checks++;
    if (cyc1 !== 32'd200) begin errors++; $display("FAIL run_cycles: got %0d want 200", cyc1); end
    checks++;
    if (obs1.size() != exp1.size()) begin
      errors++; $display("FAIL run_rd_count: got %0d want %0d", obs1.size(), exp1.size());
    end
    while (obs1.size() > 0 && exp1.size() > 0) begin
      logic [7:0] a, e;
      a = obs1.pop_front(); e = exp1.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL run_rd_addr: got %0h want %0h", a, e); end
    end
    exp1.delete(); obs1.delete();
    // DONE ignores halt/pc and keeps every status stable
    halt = 1'b1; pc = 9'h0;
    repeat (5) @(negedge clk);
    halt = 1'b0;
    checks++;
    if ({done1, pass1, cyc1, obs1.size() == 0} !== {2'b11, 32'd200, 1'b1}) begin
      errors++; $display("FAIL done_stable: done=%b pass=%b cycles=%0d reads=%0d want 1 1 200 0",
                         done1, pass1, cyc1, obs1.size());
    end
  endtask

  task automatic test_wrong_pc();
    int n;
    exp_pc = 9'hF; pc = 9'hE;
    chk_addr1 = 8'h14; chk_data1 = 16'd850;
    do_reset();
    halt_at(20);
    wait_done(1'b0, 20, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL pc_latency: got %0d want 1", n); end
    checks++;
    if ({fc1, pass1, done1} !== 4'b1001) begin
      errors++; $display("FAIL pc_status: fc=%0d pass=%b done=%b want 2 0 1", fc1, pass1, done1);
    end
    checks++;
    if (obs1.size() != 0) begin errors++; $display("FAIL pc_rd_count: got %0d want 0", obs1.size()); end
    checks++;
    if (cyc1 !== 32'd20) begin errors++; $display("FAIL pc_cycles: got %0d want 20", cyc1); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    wait_done(1'b1, 200, n);
    checks++;
    if (n !== 50) begin errors++; $display("FAIL timeout_latency: got %0d want 50", n); end
    checks++;
    if ({fc4, pass4} !== 3'b010) begin errors++; $display("FAIL timeout_code: fc=%0d pass=%b want 1 0", fc4, pass4); end
    checks++;
    if (cyc4 !== 32'd50) begin errors++; $display("FAIL timeout_cycles: got %0d want 50", cyc4); end
  endtask

  task automatic test_halt_at_timeout();
    int n;
    exp_pc = 9'h3; pc = 9'h3;
    set_table4(16'd100, 16'd200, 16'd300, 16'd400);
    do_reset();
    for (int i = 0; i < 4; i++) exp4.push_back(8'h20 + 8'(i));
    halt_at(50);
    wait_done(1'b1, 30, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL halt50_latency: got %0d want 9", n); end
    checks++;
    if ({fc4, pass4, ec4} !== 8'b00_1_00000) begin
      errors++; $display("FAIL halt50_status: fc=%0d pass=%b ec=%0d want 0 1 0", fc4, pass4, ec4);
    end
    checks++;
    if (cyc4 !== 32'd50) begin errors++; $display("FAIL halt50_cycles: got %0d want 50", cyc4); end
    checks++;
    if (obs4.size() != exp4.size()) begin
      errors++; $display("FAIL halt50_rd_count: got %0d want %0d", obs4.size(), exp4.size());
    end
    while (obs4.size() > 0 && exp4.size() > 0) begin
      logic [7:0] a, e;
      a = obs4.pop_front(); e = exp4.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL halt50_rd_addr: got %0h want %0h", a, e); end
    end
    exp4.delete(); obs4.delete();
  endtask

  task automatic test_multi_mismatch();
    int n, want_n;
    logic [4:0] want_ec;
    exp_pc = 9'h3; pc = 9'h3;
    set_table4(16'd100, 16'd201, 16'd300, 16'd401);
    do_reset();
`ifdef MRC_CONTINUE_ON_ERR_EN
    for (int i = 0; i < 4; i++) exp4.push_back(8'h20 + 8'(i));
    want_ec = 5'd2; want_n = 9;
`else
    for (int i = 0; i < 2; i++) exp4.push_back(8'h20 + 8'(i));
    want_ec = 5'd1; want_n = 5;
`endif
    halt_at(10);
    wait_done(1'b1, 30, n);
    checks++;
    if (n !== want_n) begin errors++; $display("FAIL mm_latency: got %0d want %0d", n, want_n); end
    checks++;
    if ({fc4, fi4, pass4} !== 7'b11_0001_0) begin
      errors++; $display("FAIL mm_status: fc=%0d fi=%0d pass=%b want 3 1 0", fc4, fi4, pass4);
    end
    checks++;
    if (ec4 !== want_ec) begin errors++; $display("FAIL mm_err_count: got %0d want %0d", ec4, want_ec); end
    checks++;
    if (obs4.size() != exp4.size()) begin
      errors++; $display("FAIL mm_rd_count: got %0d want %0d", obs4.size(), exp4.size());
    end
    while (obs4.size() > 0 && exp4.size() > 0) begin
      logic [7:0] a, e;
      a = obs4.pop_front(); e = exp4.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL mm_rd_addr: got %0h want %0h", a, e); end
    end
    exp4.delete(); obs4.delete();
  endtask

  task automatic test_reset_mid_check();
    int n;
    exp_pc = 9'h3; pc = 9'h3;
    set_table4(16'd100, 16'd200, 16'd300, 16'd400);
    do_reset();
    halt_at(10);
    // edges 11..16: RD0 CMP0 RD1 CMP1 RD2 CMP2
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs4.size() != 3) begin errors++; $display("FAIL mid_rd_count: got %0d want 3", obs4.size()); end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy4, done4, m4.mem_rd, cyc4, ec4, fc4} !== {3'b100, 32'd0, 5'd0, 2'd0}) begin
      errors++; $display("FAIL mid_reset: busy=%b done=%b rd=%b cycles=%0d ec=%0d fc=%0d want 1 0 0 0 0 0",
                         busy4, done4, m4.mem_rd, cyc4, ec4, fc4);
    end
    reset_n = 1'b1;
    obs4.delete();
    for (int i = 0; i < 4; i++) exp4.push_back(8'h20 + 8'(i));
    halt_at(5);
    wait_done(1'b1, 30, n);
    checks++;
    if ({done4, pass4, cyc4} !== {2'b11, 32'd5}) begin
      errors++; $display("FAIL mid_rerun: done=%b pass=%b cycles=%0d want 1 1 5", done4, pass4, cyc4);
    end
    checks++;
    if (obs4.size() != exp4.size()) begin
      errors++; $display("FAIL mid_rerun_rd_count: got %0d want %0d", obs4.size(), exp4.size());
    end
    while (obs4.size() > 0 && exp4.size() > 0) begin
      logic [7:0] a, e;
      a = obs4.pop_front(); e = exp4.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL mid_rerun_rd_addr: got %0h want %0h", a, e); end
    end
    exp4.delete(); obs4.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h14] = 16'd850;
    mem[8'h20] = 16'd100;
    mem[8'h21] = 16'd200;
    mem[8'h22] = 16'd300;
    mem[8'h23] = 16'd400;
    test_reset();
    test_correct_run();
    test_wrong_pc();
    test_timeout();
    test_halt_at_timeout();
    test_multi_mismatch();
    test_reset_mid_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
